// File: rtl/rst_seq_gen_if.sv
// Signal bundle between the reset sequencer and its environment.
// The sequencer side uses the master modport; pll/software/watchdog stimulus comes from the slave side.
interface rst_seq_gen_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
);
    logic             pll_locked;
    logic             soft_rst_req;
    logic             wdog_kick;
    logic [N_CH-1:0]  rst_n;
    logic             seq_done;
    logic [1:0]       last_cause;
    logic             wdog_expired;
    logic [CNT_W-1:0] lock_loss_cnt;
    logic [1:0]       dbg_state;

    modport master (
        input  pll_locked, soft_rst_req, wdog_kick,
        output rst_n, seq_done, last_cause, wdog_expired, lock_loss_cnt, dbg_state
    );

    modport slave (
        output pll_locked, soft_rst_req, wdog_kick,
        input  rst_n, seq_done, last_cause, wdog_expired, lock_loss_cnt, dbg_state
    );
endinterface

// File: rtl/rst_seq_gen.sv
// Multi-channel reset sequencer: hold, lock filter, staged per-channel release, and
// re-sequencing on lock loss, software request or watchdog expiry. All outputs registered.
module rst_seq_gen #(
    parameter int N_CH       = 4,
    parameter int MIN_ASSERT = 32,
    parameter int LOCK_FILT  = 8,
    parameter int STAGE_DLY  = 16,
    parameter int WDOG_WIDTH = 26,
    parameter bit WDOG_EN    = 1'b1,
    parameter int CNT_W      = 8
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    rst_seq_gen_if.master bus
);
    localparam int HOLD_W = $clog2(MIN_ASSERT + 1);
    localparam int LOCK_W = $clog2(LOCK_FILT + 1);
    localparam int DLY_W  = $clog2(STAGE_DLY + 1);
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [LOCK_W-1:0]     lock_cnt_q, lock_cnt_d;
    logic [DLY_W-1:0]      dly_cnt_q, dly_cnt_d;
    logic [CH_W-1:0]       ch_idx_q, ch_idx_d;
    logic [WDOG_WIDTH-1:0] wdog_cnt_q, wdog_cnt_d;
    logic [N_CH-1:0]       rst_n_q, rst_n_d;
    logic                  seq_done_q, seq_done_d;
    logic [1:0]            cause_q, cause_d;
    logic                  wdx_q, wdx_d;
    logic [CNT_W-1:0]      llc_q, llc_d;

    logic ev_lock, ev_soft, ev_wdog, ev_active;

    always_comb begin
        ev_lock   = !bus.pll_locked;
        ev_soft   = bus.soft_rst_req;
        ev_wdog   = WDOG_EN && (wdog_cnt_q == '1) && !bus.wdog_kick;
        ev_active = (state_q == RELEASE) || (state_q == RUN);
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        lock_cnt_d = lock_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        ch_idx_d   = ch_idx_q;
        wdog_cnt_d = wdog_cnt_q;
        rst_n_d    = rst_n_q;
        cause_d    = cause_q;
        wdx_d      = wdx_q;
        llc_d      = llc_q;

        case (state_q)
            HOLD: begin
                rst_n_d = '0;
                if (hold_cnt_q == HOLD_W'(MIN_ASSERT - 1)) begin
                    state_d    = WAIT_LOCK;
                    hold_cnt_d = '0;
                    lock_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (!bus.pll_locked) begin
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_W'(LOCK_FILT - 1)) begin
                    state_d    = RELEASE;
                    lock_cnt_d = '0;
                    ch_idx_d   = '0;
                    dly_cnt_d  = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            RELEASE: begin
                if (dly_cnt_q == DLY_W'(STAGE_DLY - 1)) begin
                    dly_cnt_d = '0;
                    for (int k = 0; k < N_CH; k++) begin
                        if (CH_W'(k) == ch_idx_q) rst_n_d[k] = 1'b1;
                    end
                    if (ch_idx_q == CH_W'(N_CH - 1)) begin
                        state_d  = RUN;
                        ch_idx_d = '0;
                    end else begin
                        ch_idx_d = ch_idx_q + CH_W'(1);
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q + DLY_W'(1);
                end
            end
            RUN: begin
                // Kick wins over expiry; an expiring count is overridden by the re-sequence below.
                if (WDOG_EN) begin
                    if (bus.wdog_kick) wdog_cnt_d = '0;
                    else               wdog_cnt_d = wdog_cnt_q + WDOG_WIDTH'(1);
                end
            end
            default: state_d = HOLD;
        endcase

        if (ev_active && (ev_lock || ev_soft || ev_wdog)) begin
            state_d    = HOLD;
            hold_cnt_d = '0;
            lock_cnt_d = '0;
            dly_cnt_d  = '0;
            ch_idx_d   = '0;
            wdog_cnt_d = '0;
            rst_n_d    = '0;
            if (ev_lock) begin
                cause_d = 2'd1;
                if (llc_q != '1) llc_d = llc_q + CNT_W'(1);
            end else if (ev_soft) begin
                cause_d = 2'd2;
            end else begin
                cause_d = 2'd3;
                wdx_d   = 1'b1;
            end
        end

        seq_done_d = (state_d == RUN);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= HOLD;
            hold_cnt_q <= '0;
            lock_cnt_q <= '0;
            dly_cnt_q  <= '0;
            ch_idx_q   <= '0;
            wdog_cnt_q <= '0;
            rst_n_q    <= '0;
            seq_done_q <= 1'b0;
            cause_q    <= 2'd0;
            wdx_q      <= 1'b0;
            llc_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            lock_cnt_q <= lock_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            ch_idx_q   <= ch_idx_d;
            wdog_cnt_q <= wdog_cnt_d;
            rst_n_q    <= rst_n_d;
            seq_done_q <= seq_done_d;
            cause_q    <= cause_d;
            wdx_q      <= wdx_d;
            llc_q      <= llc_d;
        end
    end

    assign bus.rst_n         = rst_n_q;
    assign bus.seq_done      = seq_done_q;
    assign bus.last_cause    = cause_q;
    assign bus.wdog_expired  = wdx_q;
    assign bus.lock_loss_cnt = llc_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: expected output snapshots are queued with the edge number at which
// they must hold and compared at the following falling edge.
module tb_rst_seq_gen;
    localparam int N_CH       = 4;
    localparam int MIN_ASSERT = 32;
    localparam int LOCK_FILT  = 8;
    localparam int STAGE_DLY  = 16;
    localparam int WDOG_WIDTH = 6;
    localparam int CNT_W      = 2;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   edge_cnt = 0;

    rst_seq_gen_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    rst_seq_gen #(
        .N_CH(N_CH), .MIN_ASSERT(MIN_ASSERT), .LOCK_FILT(LOCK_FILT), .STAGE_DLY(STAGE_DLY),
        .WDOG_WIDTH(WDOG_WIDTH), .WDOG_EN(1'b1), .CNT_W(CNT_W)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    // clock / reset
    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

    // scoreboard: snapshot = {rst_n, seq_done, last_cause, wdog_expired, lock_loss_cnt}
    logic [9:0] exp_q[$];
    int         cyc_q[$];
    string      tag_q[$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] snap(input logic [3:0] r, input logic sd, input logic [1:0] c,
                                        input logic w, input logic [1:0] l);
        return {r, sd, c, w, l};
    endfunction

    task automatic expect_at(input int e, input logic [9:0] v, input string tag);
        cyc_q.push_back(e);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    always @(negedge sys_clk) begin
        string      t;
        int         c;
        logic [9:0] e;
        logic [9:0] obs;
        obs = {bus.rst_n, bus.seq_done, bus.last_cause, bus.wdog_expired, bus.lock_loss_cnt};
        while (cyc_q.size() > 0 && cyc_q[0] <= edge_cnt) begin
            c = cyc_q.pop_front();
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_val($sformatf("%s@%0d", t, c), {22'd0, obs}, {22'd0, e});
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge sys_clk);
        #1;
    endtask

    task automatic wait_until(input int e);
        while (edge_cnt < e) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout edge=%0d", edge_cnt);
        $fatal(1, "timeout");
    end

    initial begin
        int base, d, s, l, r, d0, d1, d2, d3, d4, rr, g, h, b2, e;

        bus.pll_locked   = 1'b1;
        bus.soft_rst_req = 1'b0;
        bus.wdog_kick    = 1'b0;
        repeat (3) tick();
        sys_rst = 1'b0;
        base = edge_cnt;

        // power-up sequence: first low-sampled edge is base+1
        expect_at(base + 1,   snap(4'h0, 0, 0, 0, 0), "reset_state");
        expect_at(base + 55,  snap(4'h0, 0, 0, 0, 0), "pre_rel0");
        expect_at(base + 56,  snap(4'h1, 0, 0, 0, 0), "rel0");
        expect_at(base + 71,  snap(4'h1, 0, 0, 0, 0), "pre_rel1");
        expect_at(base + 72,  snap(4'h3, 0, 0, 0, 0), "rel1");
        expect_at(base + 88,  snap(4'h7, 0, 0, 0, 0), "rel2");
        expect_at(base + 103, snap(4'h7, 0, 0, 0, 0), "pre_rel3");
        expect_at(base + 104, snap(4'hF, 1, 0, 0, 0), "rel3_done");
        wait_until(base + 109);

        // lock loss in RUN, then full re-sequence from the drop edge
        d = edge_cnt + 1;
        bus.pll_locked = 1'b0;
        expect_at(d,       snap(4'h0, 0, 1, 0, 1), "drop_run");
        expect_at(d + 55,  snap(4'h0, 0, 1, 0, 1), "drop_pre_rel0");
        expect_at(d + 56,  snap(4'h1, 0, 1, 0, 1), "drop_rel0");
        expect_at(d + 72,  snap(4'h3, 0, 1, 0, 1), "drop_rel1");
        expect_at(d + 104, snap(4'hF, 1, 1, 0, 1), "drop_done");
        tick();
        bus.pll_locked = 1'b1;
        wait_until(d + 109);

        // soft request pulse, then lock chatter during WAIT_LOCK
        s = edge_cnt + 1;
        bus.soft_rst_req = 1'b1;
        expect_at(s, snap(4'h0, 0, 2, 0, 1), "soft_run");
        tick();
        bus.soft_rst_req = 1'b0;
        l = s + 70;
        expect_at(s + 72, snap(4'h0, 0, 2, 0, 1), "chatter_hold");
        expect_at(l + 23, snap(4'h0, 0, 2, 0, 1), "chatter_pre_rel0");
        expect_at(l + 24, snap(4'h1, 0, 2, 0, 1), "chatter_rel0");
        expect_at(l + 72, snap(4'hF, 1, 2, 0, 1), "chatter_done");
        while (edge_cnt < s + 72) begin
            e = edge_cnt + 1;
            bus.pll_locked = !(e >= s + 33 && ((e - s) % 5) == 0);
            tick();
        end
        bus.pll_locked = 1'b1;
        wait_until(l + 73);
        r = l + 72;

        // repeated drops, mostly during RELEASE, saturating the 2-bit counter
        wait_until(r + 1);
        bus.pll_locked = 1'b0;
        d0 = r + 2;
        expect_at(d0, snap(4'h0, 0, 1, 0, 2), "drop2");
        tick();
        bus.pll_locked = 1'b1;
        expect_at(d0 + 72, snap(4'h3, 0, 1, 0, 2), "d0_rel1");
        expect_at(d0 + 74, snap(4'h3, 0, 1, 0, 2), "d0_pre_drop");
        wait_until(d0 + 74);
        bus.pll_locked = 1'b0;
        d1 = d0 + 75;
        expect_at(d1, snap(4'h0, 0, 1, 0, 3), "drop3_release");
        tick();
        bus.pll_locked = 1'b1;
        expect_at(d1 + 56, snap(4'h1, 0, 1, 0, 3), "d1_rel0");
        wait_until(d1 + 59);
        bus.pll_locked = 1'b0;
        d2 = d1 + 60;
        expect_at(d2, snap(4'h0, 0, 1, 0, 3), "drop4_sat");
        tick();
        bus.pll_locked = 1'b1;
        expect_at(d2 + 99, snap(4'h7, 0, 1, 0, 3), "d2_rel2");
        wait_until(d2 + 99);
        bus.pll_locked = 1'b0;
        d3 = d2 + 100;
        expect_at(d3, snap(4'h0, 0, 1, 0, 3), "drop5_sat");
        tick();
        bus.pll_locked = 1'b1;

        // watchdog expiry 64 cycles after RUN entry with no kicks
        expect_at(d3 + 104, snap(4'hF, 1, 1, 0, 3), "d3_run");
        expect_at(d3 + 167, snap(4'hF, 1, 1, 0, 3), "wdog_pre");
        expect_at(d3 + 168, snap(4'h0, 0, 3, 1, 3), "wdog_expire");
        d4 = d3 + 168;
        expect_at(d4 + 104, snap(4'hF, 1, 3, 1, 3), "wdog_reseq_done");
        wait_until(d4 + 104);
        rr = d4 + 104;

        // kicks every 60 cycles keep RUN alive
        for (int k = 100; k <= 1000; k += 100)
            expect_at(rr + k, snap(4'hF, 1, 3, 1, 3), "kicked_run");
        while (edge_cnt < rr + 1000) begin
            e = edge_cnt + 1;
            bus.wdog_kick = (((e - rr) % 60) == 0);
            tick();
        end
        bus.wdog_kick = 1'b0;

        // lock loss beats soft request on the same edge; held soft keeps cycling
        g = edge_cnt + 1;
        bus.pll_locked   = 1'b0;
        bus.soft_rst_req = 1'b1;
        expect_at(g, snap(4'h0, 0, 1, 1, 3), "lock_vs_soft");
        tick();
        bus.pll_locked = 1'b1;
        expect_at(g + 40, snap(4'h0, 0, 1, 1, 3), "soft_held_release");
        expect_at(g + 41, snap(4'h0, 0, 2, 1, 3), "soft_held_retrig1");
        expect_at(g + 60, snap(4'h0, 0, 2, 1, 3), "soft_held_norel");
        expect_at(g + 82, snap(4'h0, 0, 2, 1, 3), "soft_held_retrig2");
        wait_until(g + 82);
        bus.soft_rst_req = 1'b0;
        h = g + 82;

        // sys_rst in RUN clears everything, including sticky flags
        expect_at(h + 104, snap(4'hF, 1, 2, 1, 3), "pre_sysrst_run");
        wait_until(h + 109);
        sys_rst = 1'b1;
        expect_at(h + 110, snap(4'h0, 0, 0, 0, 0), "sysrst_in_run");
        tick();
        sys_rst = 1'b0;
        b2 = edge_cnt;
        expect_at(b2 + 55, snap(4'h0, 0, 0, 0, 0), "post_rst_pre_rel0");
        expect_at(b2 + 56, snap(4'h1, 0, 0, 0, 0), "post_rst_rel0");
        wait_until(b2 + 60);
        tick();

        check_val("queue_drained", cyc_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
